// File: rtl/stn_capture.sv
// stn_capture: samples the S1D13700 STN panel bus, packs nibbles into bytes and
// issues addressed byte writes to the line buffer, flagging malformed lines/frames.
module stn_capture #(
    parameter int unsigned H_PIX   = 320,
    parameter int unsigned V_LINES = 240,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned LINE_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stn_fpframe,
    input  logic              stn_fpline,
    input  logic              stn_fpshift,
    input  logic [3:0]        stn_fpdat,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_col,
    output logic [LINE_W-1:0] wr_line,
    output logic [7:0]        wr_data,
    output logic              line_done,
    output logic              frame_start,
    output logic              err_short,
    output logic              err_long
);

    localparam int unsigned NIBS  = H_PIX / 4;
    localparam int unsigned NIB_W = $clog2(NIBS + 1);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACTIVE     = 2'd1,
        OVER       = 2'd2
    } state_t;

    // [0],[1] = two-flop synchroniser, [2] = edge-detect history
    logic [2:0] shift_sync_q;
    logic [2:0] line_sync_q;
    logic [2:0] frame_sync_q;
    logic [3:0] dat_s1_q, dat_s2_q, dat_dly_q;

    logic       shift_fall_q, line_rise_q, frame_rise_q;
    logic [3:0] nib_q;

    state_t            state_q, state_d;
    logic [NIB_W-1:0]  nib_cnt_q, nib_cnt_d;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
    logic [3:0]        hold_q, hold_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_col_q, wr_col_d;
    logic [LINE_W-1:0] wr_line_q, wr_line_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              line_done_q, line_done_d;
    logic              frame_start_q, frame_start_d;
    logic              err_short_q, err_short_d;
    logic              err_long_q, err_long_d;

    // Synchronise the STN bus into clk and register the per-cycle events.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_sync_q <= '0;
            line_sync_q  <= '0;
            frame_sync_q <= '0;
            dat_s1_q     <= '0;
            dat_s2_q     <= '0;
            dat_dly_q    <= '0;
            shift_fall_q <= 1'b0;
            line_rise_q  <= 1'b0;
            frame_rise_q <= 1'b0;
            nib_q        <= '0;
        end else begin
            shift_sync_q <= {shift_sync_q[1:0], stn_fpshift};
            line_sync_q  <= {line_sync_q[1:0], stn_fpline};
            frame_sync_q <= {frame_sync_q[1:0], stn_fpframe};
            dat_s1_q     <= stn_fpdat;
            dat_s2_q     <= dat_s1_q;
            dat_dly_q    <= dat_s2_q;
            shift_fall_q <= shift_sync_q[2] & ~shift_sync_q[1];
            line_rise_q  <= line_sync_q[1] & ~line_sync_q[2];
            frame_rise_q <= frame_sync_q[1] & ~frame_sync_q[2];
            // data delayed alongside the shift history: last sample before the fall
            nib_q        <= dat_dly_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_FRAME;
            nib_cnt_q     <= '0;
            line_cnt_q    <= '0;
            hold_q        <= '0;
            wr_en_q       <= 1'b0;
            wr_col_q      <= '0;
            wr_line_q     <= '0;
            wr_data_q     <= '0;
            line_done_q   <= 1'b0;
            frame_start_q <= 1'b0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            nib_cnt_q     <= nib_cnt_d;
            line_cnt_q    <= line_cnt_d;
            hold_q        <= hold_d;
            wr_en_q       <= wr_en_d;
            wr_col_q      <= wr_col_d;
            wr_line_q     <= wr_line_d;
            wr_data_q     <= wr_data_d;
            line_done_q   <= line_done_d;
            frame_start_q <= frame_start_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
        end
    end

    // Capture FSM: nibble packing, end-of-line checks, frame restart.
    always_comb begin
        state_d       = state_q;
        nib_cnt_d     = nib_cnt_q;
        line_cnt_d    = line_cnt_q;
        hold_d        = hold_q;
        wr_en_d       = 1'b0;
        wr_col_d      = wr_col_q;
        wr_line_d     = wr_line_q;
        wr_data_d     = wr_data_q;
        line_done_d   = 1'b0;
        frame_start_d = 1'b0;
        err_short_d   = err_short_q;
        err_long_d    = err_long_q;

        unique case (state_q)
            WAIT_FRAME: begin
            end
            ACTIVE: begin
                // nibble is counted before any coincident end-of-line check
                if (shift_fall_q) begin
                    if (nib_cnt_q < NIB_W'(NIBS)) begin
                        if (!nib_cnt_q[0]) begin
                            hold_d = nib_q;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_col_d  = ADDR_W'(nib_cnt_q >> 1);
                            wr_line_d = line_cnt_q;
                            wr_data_d = {hold_q, nib_q};
                        end
                        nib_cnt_d = nib_cnt_q + NIB_W'(1);
                    end else begin
                        err_long_d = 1'b1;
                    end
                end
                if (line_rise_q) begin
                    if (nib_cnt_d == NIB_W'(NIBS)) begin
                        line_done_d = 1'b1;
                        // completing the last line is normal; data beyond it is the overflow
                        if (line_cnt_q == LINE_W'(V_LINES - 1)) begin
                            state_d = OVER;
                        end else begin
                            line_cnt_d = line_cnt_q + LINE_W'(1);
                        end
                    end else if (nib_cnt_d != '0) begin
                        err_short_d = 1'b1;
                    end
                    nib_cnt_d = '0;
                    hold_d    = '0;
                end
            end
            OVER: begin
                if (shift_fall_q) begin
                    err_long_d = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_FRAME;
            end
        endcase

        // frame restart applies after any same-cycle line handling
        if (frame_rise_q) begin
            state_d       = ACTIVE;
            frame_start_d = 1'b1;
            nib_cnt_d     = '0;
            line_cnt_d    = '0;
            hold_d        = '0;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_col      = wr_col_q;
    assign wr_line     = wr_line_q;
    assign wr_data     = wr_data_q;
    assign line_done   = line_done_q;
    assign frame_start = frame_start_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;

endmodule
